// File: rtl/matrix_select_shifter_if.sv
// Select-request handshake between the SPI frame streamer (master) and the
// matrix select shifter (slave).
interface matrix_select_shifter_if #(
  parameter int SEL_WIDTH = 4
);
  logic                 sel_valid;
  logic [SEL_WIDTH-1:0] sel_index;
  logic                 sel_ready;
  logic                 sel_done;

  modport master (output sel_valid, output sel_index, input sel_ready, input sel_done);
  modport slave  (input sel_valid, input sel_index, output sel_ready, output sel_done);
endinterface

// File: rtl/matrix_select_shifter.sv
// Drives a 74HC595 chain with an active-low one-hot matrix select pattern.
// Optional macro MATRIX_SELECT_SKIP_SAME_EN: re-selecting the current matrix skips the shift.
module matrix_select_shifter #(
  parameter int CHAIN_LENGTH = 16,
  parameter int DIV_FACTOR   = 2,
  parameter int SEL_WIDTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  matrix_select_shifter_if.slave   sel,
  input  logic                     blank,
  output logic                     shift_clk,
  output logic                     shift_ser,
  output logic                     shift_stcp,
  output logic                     shift_en,
  output logic [SEL_WIDTH-1:0]     current_index
);
  localparam int DIV_W = $clog2(DIV_FACTOR + 1);
  localparam int BIT_W = $clog2(CHAIN_LENGTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_FACTOR - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(CHAIN_LENGTH - 1);

  typedef enum logic [2:0] {IDLE, BIT_LOW, BIT_HIGH, LATCH, DONE} state_t;

  state_t                  state;
  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [CHAIN_LENGTH-1:0] pat_q;
  logic [CHAIN_LENGTH-1:0] pat_new;
  logic [SEL_WIDTH-1:0]    idx_q;
  logic [SEL_WIDTH-1:0]    idx_new;
  logic                    sel_ready_q;
  logic                    sel_done_q;
  logic                    done_seen;
  logic                    in_range;
  logic                    accept;
  logic                    div_end;
  logic                    skip;

  // Out-of-range indices resolve to all-ones so no matrix is selected.
  always_comb begin
    in_range = int'(sel.sel_index) < CHAIN_LENGTH;
    idx_new  = in_range ? sel.sel_index : '1;
    pat_new  = '1;
    for (int i = 0; i < CHAIN_LENGTH; i++) begin
      if (in_range && (int'(sel.sel_index) == i)) pat_new[i] = 1'b0;
    end
  end

  assign accept  = sel.sel_valid && sel_ready_q;
  assign div_end = (div_cnt == DIV_LAST);

`ifdef MATRIX_SELECT_SKIP_SAME_EN
  assign skip = done_seen && (idx_new == current_index);
`else
  assign skip = 1'b0;
`endif

  assign sel.sel_ready = sel_ready_q;
  assign sel.sel_done  = sel_done_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      pat_q <= pat_new;
      idx_q <= idx_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      sel_ready_q   <= 1'b1;
      sel_done_q    <= 1'b0;
      shift_clk     <= 1'b0;
      shift_ser     <= 1'b0;
      shift_stcp    <= 1'b0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      current_index <= '1;
      done_seen     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sel_ready_q <= 1'b0;
            div_cnt     <= '0;
            bit_cnt     <= BIT_TOP;
            if (skip) begin
              state      <= DONE;
              sel_done_q <= 1'b1;
            end else begin
              state     <= BIT_LOW;
              shift_ser <= pat_new[CHAIN_LENGTH-1];
            end
          end
        end
        BIT_LOW: begin
          if (div_end) begin
            div_cnt   <= '0;
            shift_clk <= 1'b1;
            state     <= BIT_HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        BIT_HIGH: begin
          if (div_end) begin
            div_cnt   <= '0;
            shift_clk <= 1'b0;
            if (bit_cnt == '0) begin
              shift_stcp <= 1'b1;
              state      <= LATCH;
            end else begin
              bit_cnt   <= bit_cnt - 1'b1;
              shift_ser <= pat_q[bit_cnt - 1'b1];
              state     <= BIT_LOW;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (div_end) begin
            div_cnt    <= '0;
            shift_stcp <= 1'b0;
            sel_done_q <= 1'b1;
            state      <= DONE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          sel_done_q    <= 1'b0;
          sel_ready_q   <= 1'b1;
          current_index <= idx_q;
          done_seen     <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs stay blanked until the first select has been latched into the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) shift_en <= 1'b1;
    else     shift_en <= blank | ~(done_seen | (state == DONE));
  end
endmodule
